countdown_ctrl: RTL and testbench

//   Sequencer for a 2-digit BCD countdown shown on two 7-segment displays.

---
 rtl/countdown_ctrl_pkg.sv | 36 +++
 rtl/countdown_ctrl_btn_cond.sv | 45 ++++
 rtl/countdown_ctrl.sv | 120 ++++++++++++
 tb/tb_countdown_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown sequencer: FSM state encoding and
// the BCD to active-low 7-segment table (bit order a..g, left to right).
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] SEG_TABLE [10] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    function automatic logic [0:6] seg_decode(input logic [3:0] digit);
        if (digit > 4'd9) return SEG_BLANK;
        return SEG_TABLE[digit];
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

endpackage

// File: rtl/countdown_ctrl_btn_cond.sv
// Button conditioner: 2-FF synchronizer, stability debounce, and a one-cycle
// registered pulse on each accepted press.
module btn_cond #(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            db_cnt   <= '0;
            pulse    <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // any bounce back to the accepted level restarts the stability window
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            stable_q <= stable;
            pulse    <= stable & ~stable_q;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// 2-digit BCD countdown sequencer: loads from switches, counts down once per
// prescaled tick, start/pause/abort via two debounced buttons, drives two HEX digits.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] load_val,
    input  logic       start_btn,
    input  logic       pause_btn,
    output logic [0:6] hex0,
    output logic [0:6] hex1,
    output logic       running,
    output logic       done
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       count;
    logic [7:0]       count_nxt;
    logic [7:0]       count_dec;
    logic [7:0]       load_clamped;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic             tick;
    logic             start_pulse;
    logic             pause_pulse;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_start_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (start_btn),
        .pulse   (start_pulse)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_pause_cond (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (pause_btn),
        .pulse   (pause_pulse)
    );

    assign load_clamped = {bcd_clamp(load_val[7:4]), bcd_clamp(load_val[3:0])};
    assign tick         = (pre == PRE_W'(TICK_DIV - 1));

    always_comb begin
        if (count[3:0] == 4'd0) count_dec = {count[7:4] - 4'd1, 4'd9};
        else                    count_dec = {count[7:4], count[3:0] - 4'd1};
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pre_nxt   = pre;
        case (state)
            IDLE: begin
                count_nxt = load_clamped;
                if (!pause_pulse && start_pulse) begin
                    if (count == 8'h00) begin
                        state_nxt = DONE;
                        count_nxt = 8'h00;
                    end else begin
                        state_nxt = RUN;
                        count_nxt = count;
                        pre_nxt   = '0;
                    end
                end
            end
            RUN: begin
                pre_nxt = tick ? '0 : pre + 1'b1;
                if (tick) begin
                    count_nxt = count_dec;
                    if (count == 8'h01) state_nxt = DONE;
                end
                // reaching zero on this tick takes precedence over a pause
                if (pause_pulse && state_nxt != DONE) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (pause_pulse)      state_nxt = IDLE;
                else if (start_pulse) state_nxt = RUN;
            end
            DONE: begin
                count_nxt = 8'h00;
                if (start_pulse && !pause_pulse) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= 8'h00;
            pre   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            pre   <= pre_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex0    <= SEG_TABLE[0];
            hex1    <= SEG_TABLE[0];
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            hex0    <= seg_decode(count[3:0]);
            hex1    <= seg_decode(count[7:4]);
            running <= (state == RUN);
            done    <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=4, DB_CYCLES=2; expected
// displays and flags are hand-timed from the button/prescaler latencies.
module tb_countdown_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] load_val;
    logic       start_btn;
    logic       pause_btn;
    logic [0:6] hex0;
    logic [0:6] hex1;
    logic       running;
    logic       done;

    int checks   = 0;
    int failures = 0;

    countdown_ctrl #(
        .TICK_DIV  (4),
        .DB_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_val  (load_val),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .hex0      (hex0),
        .hex1      (hex1),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int tens, input int units);
        check(tag, 32'({hex1, hex0}), 32'({exp_seg(tens), exp_seg(units)}));
    endtask

    // flags = {running, done}
    task automatic check_flags(input string tag, input logic [1:0] flags);
        check(tag, 32'({running, done}), 32'(flags));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raised just after edge T0: pulse seen by the FSM at T6, outputs at T7.
    // Returns just after T6 with the buttons released.
    task automatic press(input logic s, input logic p);
        start_btn = s;
        pause_btn = p;
        step(6);
        start_btn = 1'b0;
        pause_btn = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        load_val  = 8'h00;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        step(2);
        check_disp("reset_disp", 0, 0);
        check_flags("reset_flags", 2'b00);
        reset_n = 1'b1;

        // full countdown from 12 with borrow 10 -> 09
        load_val = 8'h12;
        step(3);
        check_disp("idle_12", 1, 2);
        press(1'b1, 1'b0);
        step(1);
        check_flags("run_12", 2'b10);
        check_disp("hold_12", 1, 2);
        for (int v = 11; v >= 0; v--) begin
            step(4);
            check_disp($sformatf("cnt_%0d", v), v / 10, v % 10);
        end
        check_flags("done_12", 2'b01);
        press(1'b0, 1'b1);
        step(1);
        check_flags("done_pause_ignored", 2'b01);
        step(6);
        press(1'b1, 1'b0);
        step(2);
        check_flags("done_to_idle", 2'b00);
        check_disp("done_to_idle_disp", 1, 2);

        // pause/resume with prescaler held mid-period, then abort
        load_val = 8'h05;
        step(6);
        press(1'b1, 1'b0);
        step(4);
        press(1'b0, 1'b1);
        step(1);
        check_flags("paused_flags", 2'b00);
        check_disp("paused_03", 0, 3);
        step(40);
        check_disp("frozen_03", 0, 3);
        press(1'b1, 1'b0);
        step(2);
        check_flags("resumed", 2'b10);
        check_disp("resume_hold_03", 0, 3);
        step(1);
        check_disp("resume_tick_02", 0, 2);
        press(1'b0, 1'b1);
        step(6);
        check_flags("repaused", 2'b00);
        check_disp("repaused_01", 0, 1);
        press(1'b0, 1'b1);
        step(2);
        check_flags("abort_flags", 2'b00);
        check_disp("abort_idle_05", 0, 5);

        // digit clamping and direct DONE from zero
        load_val = 8'hA7;
        step(2);
        check_disp("clamp_a7", 9, 7);
        load_val = 8'h5B;
        step(2);
        check_disp("clamp_5b", 5, 9);
        load_val = 8'h00;
        step(2);
        press(1'b1, 1'b0);
        step(1);
        check_flags("zero_done", 2'b01);
        check_disp("zero_done_disp", 0, 0);
        step(12);
        check_flags("zero_done_stays", 2'b01);
        press(1'b1, 1'b0);
        step(2);
        check_flags("zero_to_idle", 2'b00);

        // simultaneous buttons, pause on the final tick
        load_val = 8'h40;
        step(6);
        press(1'b1, 1'b0);
        step(6);
        press(1'b1, 1'b1);
        step(1);
        check_flags("both_in_run", 2'b00);
        check_disp("both_in_run_37", 3, 7);
        step(8);
        check_disp("both_frozen_37", 3, 7);
        press(1'b1, 1'b1);
        step(2);
        check_flags("both_in_pause", 2'b00);
        check_disp("both_in_pause_idle", 4, 0);
        load_val = 8'h02;
        step(6);
        press(1'b1, 1'b0);
        step(2);
        press(1'b0, 1'b1);
        step(1);
        check_flags("pause_final_tick", 2'b01);
        check_disp("pause_final_disp", 0, 0);
        step(6);
        press(1'b1, 1'b0);
        step(2);

        // asynchronous reset while running at 37
        load_val = 8'h37;
        step(2);
        press(1'b1, 1'b0);
        step(1);
        check_flags("run_37", 2'b10);
        check_disp("run_37_disp", 3, 7);
        reset_n = 1'b0;
        #1;
        check_disp("async_reset_disp", 0, 0);
        check_flags("async_reset_flags", 2'b00);
        step(2);
        reset_n = 1'b1;
        step(2);
        check_disp("post_reset_idle", 3, 7);

        // one-cycle glitch must not be accepted
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        step(10);
        check_flags("glitch_idle", 2'b00);
        check_disp("glitch_disp", 3, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
